pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. Merges the ID load-use stall request, the EX multi-cycle operation launch and exception requests into one per-stage stall vector. The vector drives the PC register and every pipeline register, including the IF/ID register's stall/stall_aluop inputs. The block also owns the multi-cycle ALU latency counter, the exception flush/redirect, and a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 114 +++++++++++
 tb/tb_pipe_stall_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Purpose: merges load-use, multi-cycle EX and exception requests into one per-stage stall/flush control.
// Latency: stall/flush/new_pc are combinational from inputs and state; counters update on the next clock edge.
// Backpressure: the stall vector is itself the pipeline backpressure; this block accepts requests every cycle.
module pipe_stall_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stallreq_id,
  input  logic        i_mc_start,
  input  logic        i_excp_valid,
  input  logic [31:0] i_excp_handler,
  output logic [5:0]  o_stall,
  output logic        o_stall_aluop,
  output logic        o_mc_done,
  output logic        o_flush,
  output logic [31:0] o_new_pc,
  output logic [15:0] o_perf_stall_cnt
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MCYCLE = 1'b1
  } state_t;

  // Launch cycle counts as the first stall cycle, so the counter starts at MC_LAT-1.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MC_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Hold PC, IF/ID, ID/EX and EX/MEM while the multi-cycle unit is busy.
  localparam logic [5:0] STALL_MC = 6'b001111;
  // Hold PC and IF/ID; ID/EX takes a bubble for the load-use hazard.
  localparam logic [5:0] STALL_LU = 6'b000111;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [15:0]      r_perf_cnt;

  logic [5:0]       w_stall;
  logic             w_stall_aluop;
  logic             w_mc_done;
  logic             w_flush;
  logic [31:0]      w_new_pc;

  // Next-state and output decode: exception beats multi-cycle beats load-use; reset forces everything to 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_stall       = 6'b000000;
    w_stall_aluop = 1'b0;
    w_mc_done     = 1'b0;
    w_flush       = 1'b0;
    w_new_pc      = 32'h0000_0000;

    if (!i_rst) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (i_excp_valid) begin
      // Any in-flight multi-cycle op is dropped without mc_done; a same-cycle mc_start is ignored.
      w_flush     = 1'b1;
      w_new_pc    = i_excp_handler;
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (r_state == ST_MCYCLE) begin
      w_stall       = STALL_MC;
      w_stall_aluop = 1'b1;
      if (r_cnt == CNT_ONE) begin
        w_mc_done   = 1'b1;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt - CNT_ONE;
      end
    end else if (i_mc_start) begin
      w_stall       = STALL_MC;
      w_stall_aluop = 1'b1;
      w_state_nxt   = ST_MCYCLE;
      w_cnt_nxt     = CNT_INIT;
    end else if (i_stallreq_id) begin
      w_stall = STALL_LU;
    end
  end

  // State and latency counter registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating count of cycles in which IF/ID is held; flush cycles never hold IF/ID.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_perf_cnt <= 16'h0000;
    end else if (w_stall[1] && (r_perf_cnt != 16'hFFFF)) begin
      r_perf_cnt <= r_perf_cnt + 16'h0001;
    end
  end

  assign o_stall          = w_stall;
  assign o_stall_aluop    = w_stall_aluop;
  assign o_mc_done        = w_mc_done;
  assign o_flush          = w_flush;
  assign o_new_pc         = w_new_pc;
  assign o_perf_stall_cnt = r_perf_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose: directed self-checking bench for pipe_stall_ctrl with a scoreboard of expected outputs.
// Latency: expectations are queued when a cycle's inputs are driven and checked at that cycle's falling edge.
// Backpressure: none; the bench drives one step per clock.
module tb_pipe_stall_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_id;
  logic        mc_start;
  logic        excp_valid;
  logic [31:0] excp_handler;
  logic [5:0]  stall;
  logic        stall_aluop;
  logic        mc_done;
  logic        flush;
  logic [31:0] new_pc;
  logic [15:0] perf_stall_cnt;

  typedef struct {
    string       tag;
    logic [5:0]  stall;
    logic        aluop;
    logic        done;
    logic        flush;
    logic [31:0] pc;
    logic [15:0] perf;
    logic        perf_known;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp;
  int          n_fail;
  logic [15:0] tb_perf;
  logic        perf_known;

  localparam logic [31:0] HDL = 32'hBFC0_0380;

  pipe_stall_ctrl #(.MC_LAT(4), .CNT_W(8)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stallreq_id    (stallreq_id),
    .i_mc_start       (mc_start),
    .i_excp_valid     (excp_valid),
    .i_excp_handler   (excp_handler),
    .o_stall          (stall),
    .o_stall_aluop    (stall_aluop),
    .o_mc_done        (mc_done),
    .o_flush          (flush),
    .o_new_pc         (new_pc),
    .o_perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  // Perf model: the counter advances at each edge out of reset where the expected stall vector holds IF/ID.
  task automatic perf_edge(input logic r, input logic [5:0] e_stall);
    if (!r) begin
      tb_perf    = 16'h0000;
      perf_known = 1'b1;
    end else if (e_stall[1] && tb_perf != 16'hFFFF) begin
      tb_perf = tb_perf + 16'h0001;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic sreq, input logic mcs,
                      input logic exv, input logic [31:0] hdl,
                      input logic [5:0] e_stall, input logic e_aluop, input logic e_done,
                      input logic e_flush, input logic [31:0] e_pc);
    exp_t e;
    exp_t g;
    rst          = r;
    stallreq_id  = sreq;
    mc_start     = mcs;
    excp_valid   = exv;
    excp_handler = hdl;
    e.tag = tag; e.stall = e_stall; e.aluop = e_aluop; e.done = e_done;
    e.flush = e_flush; e.pc = e_pc; e.perf = tb_perf; e.perf_known = perf_known;
    sb_q.push_back(e);
    @(negedge clk);
    g = sb_q.pop_front();
    chk(g.tag, "stall", {26'd0, stall}, {26'd0, g.stall});
    chk(g.tag, "stall_aluop", {31'd0, stall_aluop}, {31'd0, g.aluop});
    chk(g.tag, "mc_done", {31'd0, mc_done}, {31'd0, g.done});
    chk(g.tag, "flush", {31'd0, flush}, {31'd0, g.flush});
    chk(g.tag, "new_pc", new_pc, g.pc);
    if (g.perf_known) chk(g.tag, "perf", {16'd0, perf_stall_cnt}, {16'd0, g.perf});
    @(posedge clk);
    perf_edge(r, e_stall);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; tb_perf = 16'h0000; perf_known = 1'b0;
    rst = 1'b0; stallreq_id = 1'b0; mc_start = 1'b0; excp_valid = 1'b0; excp_handler = 32'h0;
    #1;

    // Reset with every request high: all outputs forced low.
    step("rst0", 1'b0, 1'b1, 1'b1, 1'b1, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("rst1", 1'b0, 1'b1, 1'b1, 1'b1, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("idle", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Load-use single cycle.
    step("lu",      1'b1, 1'b1, 1'b0, 1'b0, HDL, 6'b000111, 1'b0, 1'b0, 1'b0, 32'h0);
    step("lu_post", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Multi-cycle op: second mc_start at T1 and a load-use at T2 change nothing.
    step("mc_t0", 1'b1, 1'b0, 1'b1, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("mc_t1", 1'b1, 1'b0, 1'b1, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("mc_t2", 1'b1, 1'b1, 1'b0, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("mc_t3", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b001111, 1'b1, 1'b1, 1'b0, 32'h0);
    step("mc_t4", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Exception aborts an in-flight multi-cycle op.
    step("ex_t0", 1'b1, 1'b0, 1'b1, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("ex_t1", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("ex_t2", 1'b1, 1'b0, 1'b0, 1'b1, HDL, 6'b000000, 1'b0, 1'b0, 1'b1, HDL);
    step("ex_t3", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("ex_t4", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Exception, mc_start and load-use together: exception alone wins, no MCYCLE entry.
    step("sim_t0", 1'b1, 1'b1, 1'b1, 1'b1, 32'h8000_0180, 6'b000000, 1'b0, 1'b0, 1'b1, 32'h8000_0180);
    step("sim_t1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0180, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a multi-cycle op aborts it.
    step("rmc_t0", 1'b1, 1'b0, 1'b1, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("rmc_t1", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b001111, 1'b1, 1'b0, 1'b0, 32'h0);
    step("rmc_t2", 1'b0, 1'b0, 1'b0, 1'b1, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("rmc_t3", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("rmc_t4", 1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    // Saturation: hold load-use for 70000 cycles.
    stallreq_id = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge clk);
      perf_edge(1'b1, 6'b000111);
    end
    #1;
    step("sat0",  1'b1, 1'b1, 1'b0, 1'b0, HDL, 6'b000111, 1'b0, 1'b0, 1'b0, 32'h0);
    step("sat1",  1'b1, 1'b1, 1'b0, 1'b0, HDL, 6'b000111, 1'b0, 1'b0, 1'b0, 32'h0);
    step("satrs", 1'b0, 1'b1, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);
    step("satz",  1'b1, 1'b0, 1'b0, 1'b0, HDL, 6'b000000, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
